// File: rtl/elgamal_pkg.sv
// Shared definitions for the ElGamal ephemeral-key sampler: default sizes,
// FSM state type and the try-limit helper.
package elgamal_pkg;

  localparam int KS_WIDTH     = 64;
  localparam int KS_MAX_TRIES = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_WAIT,
    S_CHECK,
    S_HOLD,
    S_FAIL
  } ks_state_e;

  // Clamp the configured attempt count into the 8-bit counter's legal range.
  function automatic logic [7:0] ks_try_limit(input int n);
    if (n < 1)   return 8'd1;
    if (n > 255) return 8'd255;
    return 8'(n);
  endfunction

endpackage

// File: rtl/key_msb_mask.sv
// Combinational mask of ones from bit 0 up to the most significant set bit
// of p. Used to shrink random candidates toward the range of p.
module key_msb_mask #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] mask
);

  logic acc;

  // Smear the highest set bit of p down to bit 0.
  always_comb begin
    acc  = 1'b0;
    mask = '0;
    for (int i = WIDTH-1; i >= 0; i--) begin
      acc     = acc | p[i];
      mask[i] = acc;
    end
  end

endmodule

// File: rtl/key_sampler.sv
// Ephemeral key sampler: seeds an external LFSR generator, consumes one
// sample per rising edge of its valid, and rejection-samples k in [1, p-2].
// Optional build macro: KEY_SAMPLER_MASK_EN masks each sample down to the
// bit length of p before the range check.
module key_sampler
  import elgamal_pkg::*;
#(
  parameter int WIDTH     = KS_WIDTH,
  parameter int MAX_TRIES = KS_MAX_TRIES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [WIDTH-1:0] modulus_p,
  output logic [WIDTH-1:0] rng_seed,
  output logic             rng_tvalid,
  input  logic             rng_tvalid_in,
  input  logic [WIDTH-1:0] rng_data,
  output logic [WIDTH-1:0] k_out,
  output logic             k_valid,
  input  logic             k_ready,
  output logic             busy,
  output logic             fail
);

  localparam logic [7:0] TRY_LIMIT = ks_try_limit(MAX_TRIES);

  ks_state_e        state;
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] cand_next;
  logic [WIDTH-1:0] p_lim;
  logic [7:0]       tries;
  logic [7:0]       tries_inc;
  logic             tv_prev;
  logic             sample_edge;
  logic             in_range;

  // A held-high generator valid yields one sample only.
  assign sample_edge = rng_tvalid_in & ~tv_prev;
  // p_reg >= 3 whenever CHECK is reached, so p-2 cannot wrap.
  assign p_lim       = p_reg - WIDTH'(2);
  assign in_range    = (cand != '0) && (cand <= p_lim);
  assign tries_inc   = tries + 8'd1;

`ifdef KEY_SAMPLER_MASK_EN
  logic [WIDTH-1:0] p_mask;

  key_msb_mask #(.WIDTH(WIDTH)) u_msb_mask (
    .p    (p_reg),
    .mask (p_mask)
  );

  assign cand_next = rng_data & p_mask;
`else
  assign cand_next = rng_data;
`endif

  // Previous level of the generator valid, for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tv_prev <= 1'b0;
    else      tv_prev <= rng_tvalid_in;
  end

  // Sampler FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      rng_seed   <= '0;
      p_reg      <= '0;
      cand       <= '0;
      tries      <= '0;
      rng_tvalid <= 1'b0;
      k_out      <= '0;
      k_valid    <= 1'b0;
      busy       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rng_seed <= seed_in;
            p_reg    <= modulus_p;
            tries    <= '0;
            busy     <= 1'b1;
            state    <= S_SEED;
          end
        end
        S_SEED: begin
          if (p_reg < WIDTH'(3)) begin
            fail  <= 1'b1;
            state <= S_FAIL;
          end else begin
            rng_tvalid <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (sample_edge) begin
            cand  <= cand_next;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (in_range) begin
            k_out      <= cand;
            k_valid    <= 1'b1;
            rng_tvalid <= 1'b0;
            state      <= S_HOLD;
          end else if (tries_inc == TRY_LIMIT) begin
            tries      <= tries_inc;
            rng_tvalid <= 1'b0;
            fail       <= 1'b1;
            state      <= S_FAIL;
          end else begin
            tries <= tries_inc;
            state <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (k_ready) begin
            k_valid <= 1'b0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_FAIL: begin
          fail  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          rng_tvalid <= 1'b0;
          k_valid    <= 1'b0;
          busy       <= 1'b0;
          fail       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
